// File: rtl/vga_capture.sv
// -----------------------------------------------------------------------------
// vga_capture
//
// Receive-side VGA timing recovery and pixel capture. Samples the colour bus
// and active-low syncs from the VGA timing generator, checks line and frame
// timing against the nominal raster, and once locked emits every active pixel
// together with its (x, y) coordinate.
//
// Optional feature macro: VGA_CAP_CRC_EN
//   defined   -> CRC-16-CCITT over each frame's emitted pixels (frame_crc,
//                crc_valid)
//   undefined -> frame_crc and crc_valid are tied to 0
//
// Ports
//   clk25        in   1   pixel clock (same frequency/phase as transmitter)
//   rst          in   1   synchronous active-high reset
//   vga_red      in   4   colour bus, red
//   vga_green    in   4   colour bus, green
//   vga_blue     in   4   colour bus, blue
//   vga_hsync    in   1   horizontal sync, active low
//   vga_vsync    in   1   vertical sync, active low
//   pix_valid    out  1   pix_* carry an active pixel this cycle
//   pix_x        out  10  pixel column
//   pix_y        out  10  pixel row
//   pix_rgb      out  12  {red, green, blue}
//   frame_start  out  1   one-cycle pulse with pixel (0,0)
//   locked       out  1   timing lock
//   err_count    out  8   number of lock losses, saturates at 255
//   h_period     out  11  last measured hsync period, saturates at 2047
//   frame_crc    out  16  CRC of the last complete frame
//   crc_valid    out  1   one-cycle pulse when frame_crc updates
// -----------------------------------------------------------------------------
module vga_capture #(
  parameter int unsigned H_TOTAL           = 800,
  parameter int unsigned H_SYNC_W          = 96,
  parameter int unsigned H_FALL_TO_ACTIVE  = 144,
  parameter int unsigned H_ACTIVE          = 640,
  parameter int unsigned V_TOTAL           = 525,
  parameter int unsigned V_ACTIVE_START_HS = 35,
  parameter int unsigned V_ACTIVE          = 480,
  parameter int unsigned LOCK_FRAMES       = 2
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic [3:0]  vga_red,
  input  logic [3:0]  vga_green,
  input  logic [3:0]  vga_blue,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_count,
  output logic [10:0] h_period,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  // Constants sized to the datapaths they are compared against.
  localparam logic [11:0] H_TOTAL_C   = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_W_C  = 12'(H_SYNC_W);
  localparam logic [11:0] H_F2A_C     = 12'(H_FALL_TO_ACTIVE);
  localparam logic [11:0] H_ACTIVE_C  = 12'(H_ACTIVE);
  localparam logic [10:0] V_TOTAL_C   = 11'(V_TOTAL);
  localparam logic [10:0] V_START_C   = 11'(V_ACTIVE_START_HS);
  localparam logic [10:0] V_ACTIVE_C  = 11'(V_ACTIVE);
  localparam logic [7:0]  LOCK_C      = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage S1: input registers and edge detection
  // ---------------------------------------------------------------------------
  logic [11:0] rgb_s1_q;
  logic        hs_s1_q, vs_s1_q;
  logic        hs_prev_q, vs_prev_q;

  // Syncs reset low so that no fall can be seen until a genuine high->low
  // transition arrives after reset.
  always_ff @(posedge clk25) begin
    if (rst) begin
      rgb_s1_q  <= '0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      rgb_s1_q  <= {vga_red, vga_green, vga_blue};
      hs_s1_q   <= vga_hsync;
      vs_s1_q   <= vga_vsync;
      hs_prev_q <= hs_s1_q;
      vs_prev_q <= vs_s1_q;
    end
  end

  logic hs_fall, hs_rise, vs_fall;
  assign hs_fall = hs_prev_q & ~hs_s1_q;
  assign hs_rise = ~hs_prev_q & hs_s1_q;
  assign vs_fall = vs_prev_q & ~vs_s1_q;

  // ---------------------------------------------------------------------------
  // Horizontal and line counters
  // ---------------------------------------------------------------------------
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] h_period_q, h_period_d;
  logic [10:0] line_q, line_d;
  logic [11:0] pos;

  // h_cnt_q is cleared by the fall, so it lags the S1 sample by one: the
  // sample currently in S1 sits at position h_cnt_q+1 counted from the first
  // low hsync sample (position 0). The same value is the length of the run
  // that ends at this sample, used for both period and low-width checks.
  assign pos = {1'b0, h_cnt_q} + 12'd1;

  always_comb begin
    h_cnt_d    = h_cnt_q;
    h_period_d = h_period_q;
    line_d     = line_q;

    if (hs_fall) begin
      h_cnt_d    = '0;
      h_period_d = pos[11] ? 11'h7FF : pos[10:0];
    end else if (h_cnt_q != 11'h7FF) begin
      h_cnt_d = h_cnt_q + 11'd1;
    end

    // A coincident hsync fall is counted after the vsync clear, so the first
    // line of a frame reads 1.
    if (vs_fall) begin
      line_d = hs_fall ? 11'd1 : 11'd0;
    end else if (hs_fall && line_q != 11'h7FF) begin
      line_d = line_q + 11'd1;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      h_cnt_q    <= '0;
      h_period_q <= '0;
      line_q     <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      h_period_q <= h_period_d;
      line_q     <= line_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Timing checks
  // ---------------------------------------------------------------------------
  logic period_bad, width_bad, lines_bad, viol_now;
  logic frame_bad_q, frame_bad_d;
  logic frame_good;

  assign period_bad = hs_fall & (pos != H_TOTAL_C);
  assign width_bad  = hs_rise & (pos != H_SYNC_W_C);
  assign lines_bad  = vs_fall & (line_q != V_TOTAL_C);
  assign viol_now   = period_bad | width_bad | lines_bad;

  // The period measured on a fall coincident with vsync belongs to the frame
  // that is ending, so it takes part in that frame's verdict and the sticky
  // flag restarts clean for the new frame.
  assign frame_good = ~frame_bad_q & ~period_bad & ~width_bad & ~lines_bad;

  always_comb begin
    if (vs_fall) begin
      frame_bad_d = 1'b0;
    end else begin
      frame_bad_d = frame_bad_q | period_bad | width_bad;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      frame_bad_q <= 1'b0;
    end else begin
      frame_bad_q <= frame_bad_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      ST_SEARCH: begin
        // First vsync fall only opens a measurement window.
        if (vs_fall) begin
          state_d    = ST_MEASURE;
          good_cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (vs_fall) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_q + 8'd1 >= LOCK_C) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (viol_now) begin
          state_d    = ST_SEARCH;
          good_cnt_d = '0;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        good_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Active region and pixel output register
  // ---------------------------------------------------------------------------
  logic [11:0] x_off;
  logic [10:0] y_off;
  logic        in_x, in_y, active;

  assign x_off = pos - H_F2A_C;
  assign y_off = line_q - V_START_C;

  // On a fall cycle the counters still hold the previous line's values, so
  // such a cycle is never treated as a pixel.
  assign in_x   = ~hs_fall & ~vs_fall & (pos >= H_F2A_C) & (x_off < H_ACTIVE_C);
  assign in_y   = (line_q >= V_START_C) & (y_off < V_ACTIVE_C);
  assign active = (state_q == ST_LOCKED) & in_x & in_y;

  logic        pix_valid_q, frame_start_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [11:0] pix_rgb_q;

  always_ff @(posedge clk25) begin
    if (rst) begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
    end else begin
      pix_valid_q   <= active;
      frame_start_q <= active & (x_off == 12'd0) & (y_off == 11'd0);
      // Coordinates and colour hold their last values outside the active area.
      if (active) begin
        pix_x_q   <= x_off[9:0];
        pix_y_q   <= y_off[9:0];
        pix_rgb_q <= rgb_s1_q;
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign locked      = (state_q == ST_LOCKED);
  assign err_count   = err_cnt_q;
  assign h_period    = h_period_q;

  // ---------------------------------------------------------------------------
  // Frame CRC
  // ---------------------------------------------------------------------------
`ifdef VGA_CAP_CRC_EN
  localparam logic [9:0] LAST_X = 10'(H_ACTIVE - 1);
  localparam logic [9:0] LAST_Y = 10'(V_ACTIVE - 1);

  // CRC-16-CCITT, 16 data bits MSB first per call.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc_in,
                                             input logic [15:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic [15:0] crc_acc_q, crc_next;
  logic [15:0] frame_crc_q;
  logic        crc_valid_q;

  // Pixel (0,0) restarts the accumulator so a frame's CRC never depends on
  // what preceded it.
  always_comb begin
    crc_next = crc16_step(frame_start_q ? 16'hFFFF : crc_acc_q,
                          {4'h0, pix_rgb_q});
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      crc_acc_q   <= 16'hFFFF;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= 1'b0;
      if (state_q != ST_LOCKED) begin
        crc_acc_q <= 16'hFFFF;
      end else if (pix_valid_q) begin
        crc_acc_q <= crc_next;
        if (pix_x_q == LAST_X && pix_y_q == LAST_Y) begin
          frame_crc_q <= crc_next;
          crc_valid_q <= 1'b1;
        end
      end
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`else
  assign frame_crc = '0;
  assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// -----------------------------------------------------------------------------
// tb_vga_capture
//
// Directed bench for vga_capture on a shrunken raster (20x10 clocks, 12x5
// active) so that several frames fit in a short run. A transmitter task
// drives colour bars with optional timing faults; a negedge monitor records
// emitted pixels, lock edges and pulse timing; the main sequence compares
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_vga_capture;

  localparam int H_T     = 20;
  localparam int H_SW    = 3;
  localparam int H_F2A   = 5;
  localparam int H_ACT   = 12;
  localparam int V_T     = 10;
  localparam int V_START = 3;
  localparam int V_ACT   = 5;
  localparam int NO_ROW  = -1;
  localparam int NO_RST  = -10;

  logic        clk25 = 1'b0;
  logic        rst   = 1'b1;
  logic [3:0]  vga_red = '0, vga_green = '0, vga_blue = '0;
  logic        vga_hsync = 1'b1, vga_vsync = 1'b1;
  logic        pix_valid, frame_start, locked, crc_valid;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_rgb;
  logic [7:0]  err_count;
  logic [10:0] h_period;
  logic [15:0] frame_crc;

  vga_capture #(
    .H_TOTAL(H_T), .H_SYNC_W(H_SW), .H_FALL_TO_ACTIVE(H_F2A),
    .H_ACTIVE(H_ACT), .V_TOTAL(V_T), .V_ACTIVE_START_HS(V_START),
    .V_ACTIVE(V_ACT), .LOCK_FRAMES(2)
  ) dut (
    .clk25(clk25), .rst(rst),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .err_count(err_count),
    .h_period(h_period), .frame_crc(frame_crc), .crc_valid(crc_valid)
  );

  always #5 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int          pix_cnt = 0, crc_cnt = 0;
  int          lock_cyc = 0, fs_cyc = 0;
  logic [10:0] drop_hp = '0;
  logic [7:0]  drop_err = '0;
  logic [15:0] last_crc = '0;
  logic        locked_prev = 1'b0;
  logic [11:0] img [0:V_ACT-1][0:H_ACT-1];

  always @(negedge clk25) begin
    locked_prev <= locked;
    if (locked && !locked_prev) lock_cyc <= cyc;
    if (!locked && locked_prev) begin
      drop_hp  <= h_period;
      drop_err <= err_count;
    end
    if (pix_valid) begin
      pix_cnt <= pix_cnt + 1;
      if (pix_y < 10'(V_ACT) && pix_x < 10'(H_ACT)) img[pix_y][pix_x] <= pix_rgb;
    end
    if (frame_start) fs_cyc <= cyc;
    if (crc_valid) begin
      crc_cnt  <= crc_cnt + 1;
      last_crc <= frame_crc;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [71:0] obs,
                          input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bar(input int x);
    if (x < 3)      return 12'hFFF;
    else if (x < 6) return 12'hF00;
    else if (x < 9) return 12'h0F0;
    else            return 12'h00F;
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] crc,
                                            input logic [11:0] px);
    logic [15:0] c;
    logic [15:0] d;
    logic        fb;
    c = crc;
    d = {4'h0, px};
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  int          fall_cyc = 0, pix00_cyc = 0, frame_no = 0;
  logic        pre_locked = 1'b0;
  logic [70:0] rst_snap = '0;

  // n_lines lines; long_row gets one extra clock; narrow_row gets a hsync one
  // clock short; rst_at (step within frame) pulses reset for one clock.
  task automatic tx_frame(input int n_lines, input int long_row,
                          input int narrow_row, input int rst_at);
    int step, len, sw, x, y;
    logic [11:0] c;
    step = 0;
    for (int r = 0; r < n_lines; r++) begin
      len = (r == long_row) ? H_T + 1 : H_T;
      sw  = (r == narrow_row) ? H_SW - 1 : H_SW;
      for (int p = 0; p < len; p++) begin
        @(negedge clk25);
        if (rst_at >= 0 && step == rst_at + 1) begin
          rst_snap = {pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
                      err_count, h_period, frame_crc, crc_valid};
          rst = 1'b0;
        end
        if (rst_at >= 0 && step == rst_at) begin
          pre_locked = locked;
          rst = 1'b1;
        end
        x = p - H_F2A;
        y = r - (V_START - 1);
        vga_hsync = (p < sw) ? 1'b0 : 1'b1;
        vga_vsync = (r < 2) ? 1'b0 : 1'b1;
        c = (x >= 0 && x < H_ACT && y >= 0 && y < V_ACT) ? bar(x) : 12'h000;
        {vga_red, vga_green, vga_blue} = c;
        if (r == 0 && p == 0) fall_cyc = cyc;
        if (x == 0 && y == 0) pix00_cyc = cyc;
        step++;
      end
    end
    frame_no++;
    $display("frame %0d: lines=%0d long_row=%0d narrow_row=%0d rst_at=%0d locked=%0b err_count=%0d",
             frame_no, n_lines, long_row, narrow_row, rst_at, locked, err_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk25);
      vga_hsync = 1'b1;
      vga_vsync = 1'b1;
      {vga_red, vga_green, vga_blue} = 12'h000;
    end
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) tx_frame(V_T, NO_ROW, NO_ROW, NO_RST);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  int          base;
  logic [15:0] exp_crc;

  initial begin
    // Reset state
    repeat (4) @(negedge clk25);
    check_eq("reset_outputs",
             {pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
              err_count, h_period, frame_crc, crc_valid}, 72'd0);
    rst = 1'b0;
    idle(3);

    // Acquisition: first fall starts measuring, lock after the third fall
    clean(2);
    check_eq("no_lock_after_2_frames", locked, 1'b0);
    base = pix_cnt;
    clean(1);
    check_eq("lock_latency", lock_cyc - fall_cyc, 2);
    check_eq("locked_after_3rd_fall", locked, 1'b1);
    check_eq("pix_count_first_locked", pix_cnt - base, H_ACT * V_ACT);
    check_eq("pix_0_0_white", img[0][0], 12'hFFF);
    check_eq("pix_3_0_red", img[0][3], 12'hF00);
    check_eq("pix_7_4_green", img[4][7], 12'h0F0);
    check_eq("pix_11_4_blue", img[4][11], 12'h00F);
    check_eq("frame_start_latency", fs_cyc - pix00_cyc, 2);
    check_eq("h_period_clean", h_period, 11'(H_T));
    check_eq("err_count_clean", err_count, 8'd0);

    // Steady locked frame
    base = pix_cnt;
    clean(1);
    check_eq("pix_count_locked", pix_cnt - base, H_ACT * V_ACT);
`ifdef VGA_CAP_CRC_EN
    exp_crc = 16'hFFFF;
    for (int y = 0; y < V_ACT; y++)
      for (int x = 0; x < H_ACT; x++)
        exp_crc = crc_model(exp_crc, bar(x));
    check_eq("crc_value", last_crc, exp_crc);
`endif

    // One stretched line: lock drops at the following hsync fall
    base = pix_cnt;
    tx_frame(V_T, 4, NO_ROW, NO_RST);
    check_eq("stretch_locked", locked, 1'b0);
    check_eq("stretch_err_count", err_count, 8'd1);
    check_eq("stretch_drop_h_period", drop_hp, 11'(H_T + 1));
    check_eq("stretch_drop_err", drop_err, 8'd1);
    check_eq("stretch_pix_count", pix_cnt - base, H_ACT * 3);

    // Relock: two clean frames after the measurement restarts
    clean(2);
    check_eq("relock_not_yet", locked, 1'b0);
    base = pix_cnt;
    clean(1);
    check_eq("relock_locked", locked, 1'b1);
    check_eq("relock_latency", lock_cyc - fall_cyc, 2);
    check_eq("relock_pix_count", pix_cnt - base, H_ACT * V_ACT);

    // Short frame: detected at the next vsync fall
    tx_frame(V_T - 1, NO_ROW, NO_ROW, NO_RST);
    check_eq("short_frame_still_locked", locked, 1'b1);
    clean(1);
    check_eq("short_frame_locked", locked, 1'b0);
    check_eq("short_frame_err_count", err_count, 8'd2);

    // Narrow hsync rejects the frame while measuring
    tx_frame(V_T, NO_ROW, 3, NO_RST);
    clean(1);
    check_eq("narrow_no_lock_1", locked, 1'b0);
    clean(1);
    check_eq("narrow_no_lock_2", locked, 1'b0);

    // Lock on this frame, then reset mid-line
    tx_frame(V_T, NO_ROW, NO_ROW, 3 * H_T + 8);
    check_eq("pre_reset_locked", pre_locked, 1'b1);
    check_eq("mid_reset_outputs", rst_snap, 71'd0);
    check_eq("post_reset_err_count", err_count, 8'd0);
    clean(2);
    check_eq("reacq_not_yet", locked, 1'b0);
    clean(1);
    check_eq("reacq_locked", locked, 1'b1);
    check_eq("reacq_latency", lock_cyc - fall_cyc, 2);

    // Syncs stuck high from reset: counter saturates, no lock, no pixels
    @(negedge clk25);
    rst = 1'b1;
    @(negedge clk25);
    rst = 1'b0;
    base = pix_cnt;
    idle(2100);
    check_eq("stuck_locked", locked, 1'b0);
    check_eq("stuck_pix_count", pix_cnt - base, 0);
    check_eq("stuck_h_period", h_period, 11'd0);
    @(negedge clk25);
    vga_hsync = 1'b0;
    repeat (2) @(negedge clk25);
    vga_hsync = 1'b1;
    idle(3);
    check_eq("saturated_h_period", h_period, 11'h7FF);

`ifdef VGA_CAP_CRC_EN
    check_eq("crc_pulses", crc_cnt, 5);
`else
    check_eq("crc_off_value", frame_crc, 16'h0000);
    check_eq("crc_off_pulses", crc_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
